fetch: RTL

//  Instruction fetch stage directly upstream of decode. Owns the fetch PC, issues in-order

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: NOP encoding,
// buffer entry layout and default sizing.
package fetch_pkg;

    localparam int          FETCH_PC_BITS    = 16;
    localparam int          FETCH_DEPTH      = 2;
    localparam int          FETCH_DEPTH_BITS = $clog2(FETCH_DEPTH);
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_PC_BITS-1:0] pc;
        logic [31:0]              instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch_entry_t with synchronous clear; DEPTH must be a power of two
// so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int AW    = FETCH_DEPTH_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_data,
    output logic [AW:0]  o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full && !i_clear;
    assign w_pop   = i_pop && !o_empty && !i_clear;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Payload needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage feeding the IF/ID register; optional performance counters
// are enabled by defining FETCH_PERF_EN.
module fetch
    import fetch_pkg::*;
#(
    parameter int                 PC_BITS  = FETCH_PC_BITS,
    parameter int                 DEPTH    = FETCH_DEPTH,
    parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_BITS-1:0] redirect_pc,
    output logic               imem_req,
    output logic [PC_BITS-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [PC_BITS-1:0] pc_d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] r_pc_d;
    logic [31:0]        r_instr;
    logic [CW-1:0]      r_drop_cnt;
    logic [CW-1:0]      r_outstanding;
    logic [PC_BITS-1:0] r_tag_q [DEPTH];
    logic [AW-1:0]      r_tag_wr;
    logic [AW-1:0]      r_tag_rd;

    logic [CW-1:0]      w_buf_count;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic               w_grant;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_buf_in;
    fetch_entry_t       w_buf_out;

    // Credits count buffered words plus every request still in flight, dropped or not.
    assign imem_req  = rst_n && !redirect &&
                       (({1'b0, w_buf_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign pc_d      = r_pc_d;

    assign w_grant = imem_req && imem_gnt;
    assign w_drop  = imem_rvalid && (r_drop_cnt != '0);
    assign w_push  = imem_rvalid && !w_drop && !redirect;
    assign w_pop   = !redirect && !stall && !w_buf_empty;

    always_comb begin
        w_buf_in       = '0;
        w_buf_in.pc    = FETCH_PC_BITS'(r_tag_q[r_tag_rd]);
        w_buf_in.instr = imem_rdata;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect),
        .i_data  (w_buf_in),
        .o_data  (w_buf_out),
        .o_count (w_buf_count),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    // Request-order PC tags; dropped responses still consume their tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_grant)     r_tag_wr <= r_tag_wr + AW'(1);
            if (imem_rvalid) r_tag_rd <= r_tag_rd + AW'(1);
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) r_tag_q[r_tag_wr] <= r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
            r_instr    <= NOP_INSTR;
            r_pc_d     <= '0;
        end else if (redirect) begin
            r_pc       <= redirect_pc;
            r_drop_cnt <= r_outstanding - CW'(imem_rvalid);
            r_instr    <= NOP_INSTR;
            r_pc_d     <= '0;
        end else begin
            if (w_grant) r_pc <= r_pc + PC_BITS'(1);
            if (w_drop)  r_drop_cnt <= r_drop_cnt - CW'(1);
            if (!stall) begin
                if (!w_buf_empty) begin
                    r_instr <= w_buf_out.instr;
                    r_pc_d  <= PC_BITS'(w_buf_out.pc);
                end else begin
                    r_instr <= NOP_INSTR;
                end
            end
        end
    end

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_buf_full));

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_push && (r_perf_fetched != '1))
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (!redirect && !stall && w_buf_empty && (r_perf_bubbles != '1))
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
